mem_req_arbiter: RTL and testbench

Shares the single main-memory address redirector (x/y/z request, `data_ready` handshake, 4-bit pixel return) between several fetch engines: the im2col tile fetcher that fills the 9×9 PE-array buffer, the weight fetcher, and spares. The block arbitrates requesters round-robin and runs one redirector transaction at a time. It returns the pixel to the granted requester, or returns zero with an error flag on timeout. It sits between the fetch engines and the redirector and is the only driver of the redirector's request port.

---
 rtl/mem_req_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_req_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter that shares the main-memory address redirector between fetch engines.
// It runs one redirector transaction at a time and returns the pixel, or zero with an error flag on timeout.
module mem_req_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  input  logic [31:0]        req_x [NUM_REQ],
  input  logic [31:0]        req_y [NUM_REQ],
  input  logic [31:0]        req_z [NUM_REQ],
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] rvalid,
  output logic [3:0]         rdata,
  output logic               rerr,
  output logic               busy,
  output logic [31:0]        x,
  output logic [31:0]        y,
  output logic [31:0]        z,
  output logic               data_ready_to_mem_addr_redirect,
  input  logic               data_ready_from_mem_addr_redirect,
  input  logic [3:0]         pixel_data
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  typedef enum logic {StIdle, StWait} state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    last_q, last_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [3:0]         rdata_q, rdata_d;
  logic               rerr_q, rerr_d;
  logic [31:0]        x_q, x_d, y_q, y_d, z_q, z_d;

  logic [IdxW-1:0]    cand;
  logic [IdxW-1:0]    win_idx;
  logic               win_found;

  // First requester found when searching from last_q+1 onwards, wrapping modulo NUM_REQ.
  always_comb begin
    cand      = '0;
    win_idx   = last_q;
    win_found = 1'b0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = IdxW'((32'(last_q) + off) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // last_q doubles as the owner of the in-flight transaction.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    gnt_d    = '0;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    rerr_d   = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    case (state_q)
      StIdle: begin
        if (en && win_found) begin
          state_d        = StWait;
          last_d         = win_idx;
          cnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          x_d            = req_x[win_idx];
          y_d            = req_y[win_idx];
          z_d            = req_z[win_idx];
        end
      end
      StWait: begin
        // A response wins over a simultaneous timeout.
        if (data_ready_from_mem_addr_redirect) begin
          state_d          = StIdle;
          rvalid_d[last_q] = 1'b1;
          rdata_d          = pixel_data;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d          = StIdle;
          rvalid_d[last_q] = 1'b1;
          rdata_d          = 4'h0;
          rerr_d           = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      last_q   <= IdxW'(NUM_REQ - 1);
      cnt_q    <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
    end
  end

  assign gnt                             = gnt_q;
  assign rvalid                          = rvalid_q;
  assign rdata                           = rdata_q;
  assign rerr                            = rerr_q;
  assign busy                            = (state_q == StWait);
  assign data_ready_to_mem_addr_redirect = (state_q == StWait);
  assign x                               = x_q;
  assign y                               = y_q;
  assign z                               = z_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: a transaction-level model predicts grant and completion
// events, which a monitor pops and compares when the DUT pulses gnt or rvalid.
module tb_mem_req_arbiter;
  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned TIMEOUT = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               en = 1'b0;
  logic [NUM_REQ-1:0] req = '0;
  logic [31:0]        req_x [NUM_REQ];
  logic [31:0]        req_y [NUM_REQ];
  logic [31:0]        req_z [NUM_REQ];
  logic [NUM_REQ-1:0] gnt, rvalid;
  logic [3:0]         rdata;
  logic               rerr, busy;
  logic [31:0]        x, y, z;
  logic               rd_to;
  logic               rd_from = 1'b0;
  logic [3:0]         pixel = 4'h0;

  mem_req_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk                               (clk),
    .rst_n                             (rst_n),
    .en                                (en),
    .req                               (req),
    .req_x                             (req_x),
    .req_y                             (req_y),
    .req_z                             (req_z),
    .gnt                               (gnt),
    .rvalid                            (rvalid),
    .rdata                             (rdata),
    .rerr                              (rerr),
    .busy                              (busy),
    .x                                 (x),
    .y                                 (y),
    .z                                 (z),
    .data_ready_to_mem_addr_redirect   (rd_to),
    .data_ready_from_mem_addr_redirect (rd_from),
    .pixel_data                        (pixel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int          cyc;
    int          idx;
    logic [31:0] x, y, z;
  } gnt_ev_t;

  typedef struct {
    int          cyc;
    int          idx;
    logic [3:0]  data;
    logic        err;
    logic [31:0] x, y, z;
  } cpl_ev_t;

  gnt_ev_t gq[$];
  cpl_ev_t cq[$];

  // Transaction-level model state
  bit          m_busy = 0;
  int          m_last = NUM_REQ - 1;
  int          m_ge = 0;
  int          m_lat = 0;
  logic [31:0] m_x, m_y, m_z;
  bit          pend [NUM_REQ];
  logic [31:0] px [NUM_REQ];
  logic [31:0] py [NUM_REQ];
  logic [31:0] pz [NUM_REQ];

  // Stimulus knobs
  int                 p_new = 0;
  int                 p_en = 100;
  int                 p_spur = 0;
  int                 lat_mode = -1;
  int                 pix_force = -1;
  logic [NUM_REQ-1:0] force_new = '0;
  logic [31:0]        fx = 0, fy = 0, fz = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives inputs for the next edge k, predicts the outcome of edge k, then advances one cycle.
  task automatic step();
    int         k;
    int         w;
    bit         resp;
    bit         e;
    logic [3:0] pix;
    k = cyc + 1;
    w = -1;
    resp = 0;
    if (m_busy) begin
      if (m_lat != 0 && (k - m_ge) == m_lat) resp = 1;
    end else if ($urandom_range(99) < p_spur) begin
      resp = 1;
    end
    pix = (pix_force < 0) ? 4'($urandom) : 4'(pix_force);
    e = ($urandom_range(99) < p_en);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pend[i] && (force_new[i] || $urandom_range(99) < p_new)) begin
        pend[i] = 1;
        px[i] = force_new[i] ? fx : $urandom;
        py[i] = force_new[i] ? fy : $urandom;
        pz[i] = force_new[i] ? fz : $urandom;
      end
    end
    en = e;
    rd_from = resp;
    pixel = pix;
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i] = pend[i];
      req_x[i] = px[i];
      req_y[i] = py[i];
      req_z[i] = pz[i];
    end
    if (!m_busy) begin
      if (e) begin
        for (int off = 1; off <= NUM_REQ; off++) begin
          int c;
          c = (m_last + off) % NUM_REQ;
          if (w < 0 && pend[c]) w = c;
        end
      end
      if (w >= 0) begin
        gq.push_back('{cyc: k, idx: w, x: px[w], y: py[w], z: pz[w]});
        m_busy = 1;
        m_last = w;
        m_ge = k;
        m_x = px[w];
        m_y = py[w];
        m_z = pz[w];
        if (lat_mode >= 0) m_lat = lat_mode;
        else m_lat = ($urandom_range(9) < 3) ? 0 : $urandom_range(TIMEOUT, 1);
        pend[w] = 0;
      end
    end else if (resp) begin
      cq.push_back('{cyc: k, idx: m_last, data: pix, err: 1'b0, x: m_x, y: m_y, z: m_z});
      m_busy = 0;
    end else if ((k - m_ge) == TIMEOUT) begin
      cq.push_back('{cyc: k, idx: m_last, data: 4'h0, err: 1'b1, x: m_x, y: m_y, z: m_z});
      m_busy = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    en = 1'b0;
    rd_from = 1'b0;
    #1;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_rerr", 32'(rerr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_req_out", 32'(rd_to), 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_z", z, 0);
    gq.delete();
    cq.delete();
    m_busy = 0;
    m_last = NUM_REQ - 1;
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    p_new = 0;
    p_en = 100;
    p_spur = 0;
    force_new = '0;
    repeat ((NUM_REQ + 1) * (TIMEOUT + 2)) step();
    check("gnt_queue_drained", gq.size(), 0);
    check("cpl_queue_drained", cq.size(), 0);
  endtask

  always @(negedge clk) begin
    if (gnt != '0) begin
      if (gq.size() == 0) begin
        check("unexpected_gnt", 32'(gnt), 0);
      end else begin
        gnt_ev_t g;
        g = gq.pop_front();
        check("gnt_cycle", cyc, g.cyc);
        check("gnt_onehot", 32'(gnt), 32'(1) << g.idx);
        check("gnt_x", x, g.x);
        check("gnt_y", y, g.y);
        check("gnt_z", z, g.z);
        check("gnt_busy", 32'(busy), 1);
        check("gnt_req_out", 32'(rd_to), 1);
      end
    end
    if (rvalid != '0) begin
      if (cq.size() == 0) begin
        check("unexpected_rvalid", 32'(rvalid), 0);
      end else begin
        cpl_ev_t c;
        c = cq.pop_front();
        check("cpl_cycle", cyc, c.cyc);
        check("cpl_onehot", 32'(rvalid), 32'(1) << c.idx);
        check("cpl_rdata", 32'(rdata), 32'(c.data));
        check("cpl_rerr", 32'(rerr), 32'(c.err));
        check("cpl_x_held", x, c.x);
        check("cpl_y_held", y, c.y);
        check("cpl_z_held", z, c.z);
        check("cpl_req_out_low", 32'(rd_to), 0);
      end
    end else if (rerr) begin
      check("rerr_without_rvalid", 32'(rerr), 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_x[i] = 0;
      req_y[i] = 0;
      req_z[i] = 0;
      px[i] = 0;
      py[i] = 0;
      pz[i] = 0;
      pend[i] = 0;
    end
    @(posedge clk);
    #1;
    do_reset();

    // Single transaction: requester 0 at (3,5,1), pixel 0xA two cycles after grant.
    lat_mode = 2; pix_force = 10; fx = 3; fy = 5; fz = 1;
    force_new = 2'b01;
    step();
    force_new = '0;
    repeat (6) step();

    // Both requesting continuously, zero-wait redirector: alternating grants every 2 cycles.
    lat_mode = 1; pix_force = -1;
    force_new = 2'b11;
    repeat (12) step();
    drain();

    // Silent redirector: error completion TIMEOUT cycles after grant, late responses ignored.
    lat_mode = 0; p_spur = 100;
    force_new = 2'b01;
    step();
    force_new = '0;
    repeat (TIMEOUT + 6) step();
    p_spur = 0;

    // Response in the same cycle as the timeout expiry.
    lat_mode = TIMEOUT; fx = 7; fy = 8; fz = 9;
    force_new = 2'b10;
    step();
    force_new = '0;
    repeat (TIMEOUT + 3) step();

    // en low holds off the grant; raising it grants one cycle later.
    lat_mode = 1;
    p_en = 0;
    force_new = 2'b10;
    repeat (5) step();
    p_en = 100;
    force_new = '0;
    repeat (4) step();

    // Reset mid-WAIT abandons the transaction; requester 0 wins the next contention.
    lat_mode = 0;
    force_new = 2'b01;
    step();
    force_new = '0;
    repeat (4) step();
    do_reset();
    lat_mode = 1;
    force_new = 2'b11;
    step();
    force_new = '0;
    repeat (4) step();
    drain();

    // Randomised traffic.
    p_new = 30; p_en = 80; p_spur = 10; lat_mode = -1; pix_force = -1;
    repeat (2000) step();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
